// File: rtl/alu_result_writeback_if.sv
// Handshake and bus signals between the ALU result writeback block, the ALU/control side
// and the 32-bit datapath bus.
interface alu_result_writeback_if;
    logic        start;
    logic [4:0]  opcode;
    logic [63:0] Z_in;
    logic        idle;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_out;
    logic [1:0]  dest_sel;

    // master: the ALU/control unit plus the bus consumer.
    modport master (
        output start, opcode, Z_in, bus_ready,
        input  idle, bus_valid, bus_out, dest_sel
    );

    // slave: the writeback block itself.
    modport slave (
        input  start, opcode, Z_in, bus_ready,
        output idle, bus_valid, bus_out, dest_sel
    );
endinterface

// File: rtl/alu_result_writeback.sv
// Captures the 64-bit ALU result and streams it onto the 32-bit bus as LO/HI beats or
// one GPR beat, maintaining HI/LO. Optional macro WB_FLAGS_EN adds zero/neg flags.
module alu_result_writeback #(
    parameter logic [4:0]  MUL_OP         = 5'b10000,
    parameter logic [4:0]  DIV_OP         = 5'b01111,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                    clock,
    input  logic                    clear,
    alu_result_writeback_if.slave   wb,
    output logic [31:0]             HI_out,
    output logic [31:0]             LO_out,
    output logic                    done,
    output logic                    timeout_err
`ifdef WB_FLAGS_EN
    ,
    output logic                    zero_flag,
    output logic                    neg_flag
`endif
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] STALL_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_LO,
        S_SEND_HI,
        S_SEND_GP,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [31:0]   zhi_q;
    logic [31:0]   zlo_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [31:0]   bus_out_q;
    logic [1:0]    dest_q;
    logic          bus_valid_q;
    logic          idle_q;
    logic          done_q;
    logic          timeout_q;
    logic [CW-1:0] stall_q;
    logic          wide_d;
`ifdef WB_FLAGS_EN
    logic          zero_q;
    logic          neg_q;
`endif

    assign wide_d = (wb.opcode == MUL_OP) || (wb.opcode == DIV_OP);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= S_IDLE;
            zhi_q       <= '0;
            zlo_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            bus_out_q   <= '0;
            dest_q      <= 2'b00;
            bus_valid_q <= 1'b0;
            idle_q      <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            stall_q     <= '0;
`ifdef WB_FLAGS_EN
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (wb.start) begin
                        zhi_q       <= wb.Z_in[63:32];
                        zlo_q       <= wb.Z_in[31:0];
                        // The first beat is always the low word, so load it straight from Z_in.
                        bus_out_q   <= wb.Z_in[31:0];
                        bus_valid_q <= 1'b1;
                        idle_q      <= 1'b0;
                        stall_q     <= '0;
                        state_q     <= wide_d ? S_SEND_LO : S_SEND_GP;
                        dest_q      <= wide_d ? 2'b01 : 2'b11;
`ifdef WB_FLAGS_EN
                        zero_q      <= wide_d ? (wb.Z_in == 64'd0) : (wb.Z_in[31:0] == 32'd0);
                        neg_q       <= wide_d ? wb.Z_in[63] : wb.Z_in[31];
`endif
                    end
                end
                S_SEND_LO, S_SEND_HI, S_SEND_GP: begin
                    if (wb.bus_ready) begin
                        stall_q <= '0;
                        if (state_q == S_SEND_LO) begin
                            lo_q      <= zlo_q;
                            bus_out_q <= zhi_q;
                            dest_q    <= 2'b10;
                            state_q   <= S_SEND_HI;
                        end else begin
                            if (state_q == S_SEND_HI) begin
                                hi_q <= zhi_q;
                            end
                            bus_valid_q <= 1'b0;
                            dest_q      <= 2'b00;
                            done_q      <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end else if (TIMEOUT_CYCLES != 0) begin
                        // Abort drops the untransferred beats; HI/LO keep what already landed.
                        if (stall_q == STALL_LAST) begin
                            stall_q     <= '0;
                            bus_valid_q <= 1'b0;
                            dest_q      <= 2'b00;
                            timeout_q   <= 1'b1;
                            idle_q      <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            stall_q <= stall_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    idle_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    bus_valid_q <= 1'b0;
                    dest_q      <= 2'b00;
                    idle_q      <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign wb.idle      = idle_q;
    assign wb.bus_valid = bus_valid_q;
    assign wb.bus_out   = bus_out_q;
    assign wb.dest_sel  = dest_q;
    assign HI_out       = hi_q;
    assign LO_out       = lo_q;
    assign done         = done_q;
    assign timeout_err  = timeout_q;
`ifdef WB_FLAGS_EN
    assign zero_flag    = zero_q;
    assign neg_flag     = neg_q;
`endif
endmodule

// File: tb/tb_alu_result_writeback.sv
// Randomized scoreboard bench for alu_result_writeback, built with a 4-cycle bus timeout.
module tb_alu_result_writeback;
    localparam logic [4:0] MUL_OP = 5'b10000;
    localparam logic [4:0] DIV_OP = 5'b01111;
    localparam int         TO     = 4;

    logic        clock;
    logic        clear;
    logic [31:0] HI_out;
    logic [31:0] LO_out;
    logic        done;
    logic        timeout_err;

    alu_result_writeback_if wb_if ();

    alu_result_writeback #(
        .MUL_OP         (MUL_OP),
        .DIV_OP         (DIV_OP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .wb          (wb_if),
        .HI_out      (HI_out),
        .LO_out      (LO_out),
        .done        (done),
        .timeout_err (timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // kind: 0 = bus beat, 1 = done pulse, 2 = timeout pulse
    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [1:0]  dest;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        expq[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] hi_m  = '0;
    logic [31:0] lo_m  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic push_ev(input int kind, input logic [31:0] data, input logic [1:0] dest);
        exp_t e;
        e.kind = kind; e.data = data; e.dest = dest; e.hi = hi_m; e.lo = lo_m;
        expq.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a beat, done or timeout.
    logic        hold_v = 1'b0;
    logic [31:0] hold_d;
    logic [1:0]  hold_s;
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #1;
            if (clear) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v && wb_if.bus_valid) begin
                    chk("hold_data", 64'(wb_if.bus_out), 64'(hold_d));
                    chk("hold_dest", 64'(wb_if.dest_sel), 64'(hold_s));
                end
                hold_v = wb_if.bus_valid && !wb_if.bus_ready;
                hold_d = wb_if.bus_out;
                hold_s = wb_if.dest_sel;
                if (wb_if.bus_valid && wb_if.bus_ready) begin
                    if (expq.size() == 0 || expq[0].kind != 0) begin
                        total++; bad++;
                        $display("FAIL beat: unexpected beat %h dest %b", wb_if.bus_out, wb_if.dest_sel);
                    end else begin
                        e = expq.pop_front();
                        chk("beat_data", 64'(wb_if.bus_out), 64'(e.data));
                        chk("beat_dest", 64'(wb_if.dest_sel), 64'(e.dest));
                    end
                end
                if (done) begin
                    if (expq.size() == 0 || expq[0].kind != 1) begin
                        total++; bad++;
                        $display("FAIL done: unexpected done pulse");
                    end else begin
                        e = expq.pop_front();
                        chk("done_hi", 64'(HI_out), 64'(e.hi));
                        chk("done_lo", 64'(LO_out), 64'(e.lo));
                        chk("done_idle", 64'(wb_if.idle), 64'd0);
                    end
                end
                if (timeout_err) begin
                    if (expq.size() == 0 || expq[0].kind != 2) begin
                        total++; bad++;
                        $display("FAIL timeout: unexpected timeout pulse");
                    end else begin
                        e = expq.pop_front();
                        chk("to_hi", 64'(HI_out), 64'(e.hi));
                        chk("to_lo", 64'(LO_out), 64'(e.lo));
                        chk("to_valid", 64'(wb_if.bus_valid), 64'd0);
                    end
                end
            end
        end
    end

    // One transaction: s0/s1 are stall cycles before each beat, junk pulses a stray start.
    task automatic run_txn(input logic [4:0] op, input logic [63:0] z,
                           input int s0, input int s1, input bit junk);
        bit wide;
        int nb, occ, cyc, beat, sc, w, s;
        bit to_hit, first;
        wide = (op == MUL_OP) || (op == DIV_OP);
        nb = wide ? 2 : 1;
        occ = 1;
        to_hit = 1'b0;
        for (int b = 0; b < nb; b++) begin
            s = (b == 0) ? s0 : s1;
            if (s >= TO) begin
                push_ev(2, '0, 2'b00);
                occ += TO;
                to_hit = 1'b1;
                break;
            end
            if (!wide)       push_ev(0, z[31:0], 2'b11);
            else if (b == 0) push_ev(0, z[31:0], 2'b01);
            else             push_ev(0, z[63:32], 2'b10);
            if (wide && b == 0) lo_m = z[31:0];
            if (wide && b == 1) hi_m = z[63:32];
            occ += s + 1;
        end
        if (!to_hit) begin
            push_ev(1, '0, 2'b00);
            occ += 1;
        end

        w = 0;
        while (!wb_if.idle && w < 50) begin
            @(negedge clock);
            w++;
        end
        chk("wait_idle", 64'(wb_if.idle), 64'd1);
        wb_if.start  = 1'b1;
        wb_if.opcode = op;
        wb_if.Z_in   = z;
        @(posedge clock);
        cyc = 1;
        @(negedge clock);
        if (junk) begin
            wb_if.opcode = 5'b00101;
            wb_if.Z_in   = 64'd9;
        end else begin
            wb_if.start = 1'b0;
        end
        beat = 0; sc = 0; first = 1'b1;
        while (!wb_if.idle && cyc < 60) begin
            if (!first) wb_if.start = 1'b0;
            first = 1'b0;
            if (wb_if.bus_valid) begin
                s = (beat == 0) ? s0 : s1;
                if (sc < s) begin
                    wb_if.bus_ready = 1'b0;
                    sc++;
                end else begin
                    wb_if.bus_ready = 1'b1;
                    beat++;
                    sc = 0;
                end
            end else begin
                wb_if.bus_ready = 1'b0;
            end
            @(posedge clock);
            cyc++;
            @(negedge clock);
        end
        wb_if.start     = 1'b0;
        wb_if.bus_ready = 1'b0;
        chk("occupancy", 64'(cyc), 64'(occ));
        $display("txn op=%b z=%h stalls=%0d/%0d junk=%0d cycles=%0d", op, z, s0, s1, junk, cyc);
    endtask

    initial begin
        logic [4:0]  op;
        logic [63:0] z;
        int          r, s0, s1;
        clear           = 1'b1;
        wb_if.start     = 1'b0;
        wb_if.opcode    = '0;
        wb_if.Z_in      = '0;
        wb_if.bus_ready = 1'b0;
        repeat (2) @(negedge clock);
        #2;
        chk("rst_idle", 64'(wb_if.idle), 64'd1);
        chk("rst_valid", 64'(wb_if.bus_valid), 64'd0);
        chk("rst_dest", 64'(wb_if.dest_sel), 64'd0);
        chk("rst_bus", 64'(wb_if.bus_out), 64'd0);
        chk("rst_hi", 64'(HI_out), 64'd0);
        chk("rst_lo", 64'(LO_out), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_to", 64'(timeout_err), 64'd0);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);

        run_txn(5'b00011, 64'h0000_0000_0000_0007, 0, 0, 1'b0);
        run_txn(MUL_OP, 64'h0000_0001_FFFF_FFFE, 0, 0, 1'b0);
        run_txn(DIV_OP, {32'd3, 32'd5}, 3, 0, 1'b1);
        run_txn(MUL_OP, 64'h1234_5678_9ABC_DEF0, 1, 2, 1'b1);
        run_txn(5'b00011, 64'hDEAD_BEEF_0000_0042, 4, 0, 1'b0);
        run_txn(DIV_OP, 64'hAAAA_0000_5555_1111, 0, 5, 1'b0);

        // Reset during the HI beat, after LO has transferred.
        push_ev(0, 32'hCAFE_0001, 2'b01);
        wb_if.start  = 1'b1;
        wb_if.opcode = MUL_OP;
        wb_if.Z_in   = 64'hBEEF_0002_CAFE_0001;
        @(posedge clock);
        @(negedge clock);
        wb_if.start     = 1'b0;
        wb_if.bus_ready = 1'b1;
        @(negedge clock);
        wb_if.bus_ready = 1'b0;
        #2 clear = 1'b1;
        #1;
        chk("midrst_valid", 64'(wb_if.bus_valid), 64'd0);
        chk("midrst_lo", 64'(LO_out), 64'd0);
        chk("midrst_hi", 64'(HI_out), 64'd0);
        chk("midrst_idle", 64'(wb_if.idle), 64'd1);
        hi_m = '0;
        lo_m = '0;
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        run_txn(5'b00100, 64'h0000_0000_1357_9BDF, 0, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 2);
            op = (r == 0) ? MUL_OP : (r == 1) ? DIV_OP : 5'($urandom_range(0, 31));
            z = {$urandom(), $urandom()};
            r = $urandom_range(0, 9);
            s0 = (r < 6) ? 0 : (r < 8) ? $urandom_range(1, 3) : $urandom_range(4, 5);
            r = $urandom_range(0, 9);
            s1 = (r < 6) ? 0 : (r < 8) ? $urandom_range(1, 3) : $urandom_range(4, 5);
            run_txn(op, z, s0, s1, ($urandom_range(0, 3) == 0));
        end

        repeat (4) @(negedge clock);
        chk("queue_empty", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end
endmodule
